dsram_responder: RTL and testbench

//  Responder for the data SRAM request port driven by the memory-access stage.

---
 rtl/dsram_responder.sv | 177 +++++++++++++++++
 tb/tb_dsram_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dsram_responder.sv
// Data SRAM responder: serves one word-organised access per request after LATENCY cycles.
// Optional address window check is enabled by defining DSRAM_RANGE_CHECK_EN.
module dsram_responder #(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        data_sram_en,
  input  logic        data_sram_wen,
  input  logic [3:0]  data_sram_sel,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        stallreq,
  output logic        access_err
);

  // state | meaning
  // IDLE  | no access in flight, may accept
  // BUSY  | counting down wait states of a captured request
  // RESP  | response cycle of a completed access, may accept the next one
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam bit MULTI = (LATENCY > 1);

  logic [31:0] mem [2**ADDR_W];

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wen_q, wen_d;
  logic [3:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                inwin_q, inwin_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                access_err_q, access_err_d;

  logic [ADDR_W-1:0]   in_word;
  logic                in_inwin;
  logic                idle_or_resp, accept, complete, ram_we;
  logic                op_wen, op_inwin;
  logic [3:0]          op_sel;
  logic [ADDR_W-1:0]   op_word;
  logic [31:0]         op_wdata;
  logic                unused_bits;

  assign in_word = data_sram_addr[ADDR_W+1:2];

`ifdef DSRAM_RANGE_CHECK_EN
  assign in_inwin = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
`else
  assign in_inwin = 1'b1;
`endif

  assign unused_bits = ^{data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2], BASE_ADDR};

  // With LATENCY==1 the access completes on its acceptance edge, so it uses the live request.
  always_comb begin
    idle_or_resp = (state_q == IDLE) || (state_q == RESP);
    accept       = idle_or_resp && data_sram_en && !flush;
    if (state_q == BUSY) begin
      op_wen   = wen_q;
      op_sel   = sel_q;
      op_word  = word_q;
      op_wdata = wdata_q;
      op_inwin = inwin_q;
    end else begin
      op_wen   = data_sram_wen;
      op_sel   = data_sram_sel;
      op_word  = in_word;
      op_wdata = data_sram_wdata;
      op_inwin = in_inwin;
    end
    complete = MULTI ? ((state_q == BUSY) && (cnt_q == CNT_ONE) && !flush) : accept;
    ram_we   = complete && op_wen && op_inwin && resetn;
    stallreq = (idle_or_resp && data_sram_en && MULTI) || ((state_q == BUSY) && (cnt_q > CNT_ONE));
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wen_d         = wen_q;
    sel_d         = sel_q;
    word_d        = word_q;
    wdata_d       = wdata_q;
    inwin_d       = inwin_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    access_err_d  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          wen_d   = data_sram_wen;
          sel_d   = data_sram_sel;
          word_d  = in_word;
          wdata_d = data_sram_wdata;
          inwin_d = in_inwin;
          if (MULTI) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (complete) begin
      rdata_valid_d = !op_wen;
      access_err_d  = !op_inwin;
      if (!op_wen) rdata_d = op_inwin ? mem[op_word] : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wen_q         <= 1'b0;
      sel_q         <= 4'h0;
      word_q        <= '0;
      wdata_q       <= 32'h0;
      inwin_q       <= 1'b0;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
      access_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wen_q         <= wen_d;
      sel_q         <= sel_d;
      word_q        <= word_d;
      wdata_q       <= wdata_d;
      inwin_q       <= inwin_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      access_err_q  <= access_err_d;
    end
  end

  // RAM has no reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (op_sel[i]) mem[op_word][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign rdata_valid     = rdata_valid_q;
  assign access_err      = access_err_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder at LATENCY 1, 3 and 4 sharing one request bus.
// Window-check expectations follow DSRAM_RANGE_CHECK_EN when it is defined.
module tb_dsram_responder;

  logic        clk = 1'b0;
  logic        resetn, flush, en, wen;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  logic [31:0] rdata1, rdata3, rdata4;
  logic        rv1, rv3, rv4, st1, st3, st4, ae1, ae3, ae4;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dsram_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .resetn(resetn), .flush(flush), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_sel(sel), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata1), .rdata_valid(rv1), .stallreq(st1), .access_err(ae1));

  dsram_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .resetn(resetn), .flush(flush), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_sel(sel), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata3), .rdata_valid(rv3), .stallreq(st3), .access_err(ae3));

  dsram_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .resetn(resetn), .flush(flush), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_sel(sel), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata4), .rdata_valid(rv4), .stallreq(st4), .access_err(ae4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic e, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; sel = s; addr = a; wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    flush  = 1'b0;
    resetn = 1'b0;
    mid();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    flush  = 1'b0;
    resetn = 1'b0;
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mid();
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rv1", 32'(rv1), 32'd0);
    chk("rst_ae1", 32'(ae1), 32'd0);
    chk("rst_rv4", 32'(rv4), 32'd0);
    chk("rst_st3", 32'(st3), 32'd0);
    tick();
    resetn = 1'b1;

    // LATENCY=1 write then read
    drv(1'b1, 1'b1, 4'hF, 32'h10, 32'h1234_5678);
    mid(); chk("t1_st_w", 32'(st1), 32'd0);
    tick();
    drv(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    mid(); chk("t1_st_r", 32'(st1), 32'd0); chk("t1_no_wpulse", 32'(rv1), 32'd0);
    tick();
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mid(); chk("t1_rv", 32'(rv1), 32'd1); chk("t1_rdata", rdata1, 32'h1234_5678);
    tick();
    mid(); chk("t1_rv_drop", 32'(rv1), 32'd0); chk("t1_hold", rdata1, 32'h1234_5678);
    tick();

    // byte lanes, plus an all-lanes-disabled write
    drv(1'b1, 1'b1, 4'hF, 32'h20, 32'hAABB_CCDD); tick();
    drv(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000_1100); tick();
    drv(1'b1, 1'b0, 4'hF, 32'h20, 32'h0); tick();
    drv(1'b1, 1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF);
    mid(); chk("t2_rv", 32'(rv1), 32'd1); chk("t2_lane", rdata1, 32'hAABB_11DD);
    tick();
    drv(1'b1, 1'b0, 4'hF, 32'h20, 32'h0); tick();
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mid(); chk("t2_sel0", rdata1, 32'hAABB_11DD);
    tick();

    // LATENCY=3 held write then held read
    do_reset();
    drv(1'b1, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D);
    mid(); chk("t3_w_st0", 32'(st3), 32'd1); tick();
    mid(); chk("t3_w_st1", 32'(st3), 32'd1); tick();
    mid(); chk("t3_w_st2", 32'(st3), 32'd0); tick();
    drv(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    mid(); chk("t3_r_st0", 32'(st3), 32'd1); chk("t3_w_nopulse", 32'(rv3), 32'd0); tick();
    mid(); chk("t3_r_st1", 32'(st3), 32'd1); chk("t3_rv_early1", 32'(rv3), 32'd0); tick();
    mid(); chk("t3_r_st2", 32'(st3), 32'd0); chk("t3_rv_early2", 32'(rv3), 32'd0); tick();
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mid(); chk("t3_rv", 32'(rv3), 32'd1); chk("t3_rdata", rdata3, 32'hCAFE_F00D);
    chk("t3_st_idle", 32'(st3), 32'd0); tick();
    mid(); chk("t3_single", 32'(rv3), 32'd0); tick();

    // LATENCY=4 flushed write is dropped
    do_reset();
    drv(1'b1, 1'b1, 4'hF, 32'h80, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); tick();
    drv(1'b1, 1'b1, 4'hF, 32'h80, 32'hFFFF_FFFF);
    mid(); chk("t4_st0", 32'(st4), 32'd1); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mid(); chk("t4_idle", 32'(st4), 32'd0); chk("t4_nopulse0", 32'(rv4), 32'd0); tick();
    for (int i = 0; i < 3; i++) begin
      mid(); chk("t4_nopulse", 32'(rv4), 32'd0); tick();
    end
    drv(1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mid(); chk("t4_rv", 32'(rv4), 32'd1); chk("t4_rdata", rdata4, 32'h0); tick();

    // LATENCY=1 back-to-back reads, then reset mid-burst
    do_reset();
    drv(1'b1, 1'b1, 4'hF, 32'h0, 32'h1111_1111); tick();
    drv(1'b1, 1'b1, 4'hF, 32'h4, 32'h2222_2222); tick();
    drv(1'b1, 1'b1, 4'hF, 32'h8, 32'h3333_3333); tick();
    drv(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    mid(); chk("t5_rv0", 32'(rv1), 32'd0); tick();
    drv(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    mid(); chk("t5_rv_a", 32'(rv1), 32'd1); chk("t5_d0", rdata1, 32'h1111_1111); tick();
    drv(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    mid(); chk("t5_rv_b", 32'(rv1), 32'd1); chk("t5_d4", rdata1, 32'h2222_2222); tick();
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mid(); chk("t5_rv_c", 32'(rv1), 32'd1); chk("t5_d8", rdata1, 32'h3333_3333); tick();
    mid(); chk("t5_rv_end", 32'(rv1), 32'd0); tick();
    drv(1'b1, 1'b0, 4'hF, 32'h4, 32'h0); tick();
    resetn = 1'b0;
    drv(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    mid(); chk("t5_rst_rv", 32'(rv1), 32'd0); chk("t5_rst_rdata", rdata1, 32'h0);
    tick();
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    resetn = 1'b1;
    tick();

    // upper address bits: window check or aliasing
    drv(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0); tick();
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mid();
    chk("t6_rv", 32'(rv1), 32'd1);
`ifdef DSRAM_RANGE_CHECK_EN
    chk("t6_oow_rdata", rdata1, 32'h0);
    chk("t6_oow_err", 32'(ae1), 32'd1);
    tick();
    drv(1'b1, 1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF); tick();
    drv(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    mid(); chk("t6_werr", 32'(ae1), 32'd1); chk("t6_w_nopulse", 32'(rv1), 32'd0); tick();
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mid(); chk("t6_word0", rdata1, 32'h1111_1111); chk("t6_inwin_err", 32'(ae1), 32'd0);
`else
    chk("t6_alias_rdata", rdata1, 32'h1111_1111);
    chk("t6_no_err", 32'(ae1), 32'd0);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
